decoder_2to4_sync: RTL and testbench
====================================

DECODER_2TO4_SYNC -- requirements
Module: decoder_2to4_sync

Interface
REQ-001 Parameter HOLD_CYC, default 4, number of cycles each decoded one-hot word is held on Y; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  code presented for decode.
REQ-005 in_ready  output  1  block can accept a code this cycle.
REQ-006 code  input  2  binary code; matches 4:2 encoder output convention (I=4'b1000 -> 2'b11).
REQ-007 Y  output  4  registered one-hot decode; 4'b0000 when idle.
REQ-008 y_valid  output  1  high while Y carries a decoded word.
REQ-009 busy  output  1  high in HOLD state.
REQ-010 hit_cnt  output  32  four 8-bit saturating counters {cnt3,cnt2,cnt1,cnt0}; present only with DECODER_HIT_CNT_EN.

Function
REQ-011 The FSM SHALL have two states: IDLE and HOLD.
REQ-012 In IDLE, in_ready SHALL be 1; in HOLD, in_ready SHALL be 0.
REQ-013 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; code SHALL be captured on that edge.
REQ-014 On acceptance, the next cycle SHALL have Y = 4'b0001 << code, y_valid=1, busy=1, state=HOLD; latency is 1 cycle.
REQ-015 Mapping: 2'b00->4'b0001, 2'b01->4'b0010, 2'b10->4'b0100, 2'b11->4'b1000.
REQ-016 On entering HOLD, the down-counter SHALL load HOLD_CYC-1; it decrements by 1 each cycle in HOLD.
REQ-017 In HOLD with counter==0, the next edge SHALL return to IDLE with Y=4'b0000, y_valid=0, busy=0.
REQ-018 Y SHALL be held stable for exactly HOLD_CYC consecutive cycles per accepted code.
REQ-019 HOLD_CYC=1 SHALL give a single-cycle Y pulse and a one-cycle IDLE gap before the next acceptance.
REQ-020 Minimum spacing between acceptances SHALL be HOLD_CYC+1 cycles.
REQ-021 in_valid and code SHALL be ignored in HOLD; a held in_valid SHALL be accepted on the first IDLE cycle.
REQ-022 Y SHALL never have more than one bit set.
REQ-023 Y SHALL equal 4'b0000 whenever y_valid=0.

Reset
REQ-024 rst=1 on an edge SHALL force IDLE, Y=4'b0000, y_valid=0, busy=0, counter=0, and in_ready=1 from the following cycle.
REQ-025 rst SHALL take priority over acceptance and HOLD progress on the same edge.
REQ-026 rst asserted mid-HOLD SHALL abort the hold immediately; the held word is not resumed.
REQ-027 Hit counters (when compiled in) SHALL clear to 0 on reset.

Configuration
REQ-028 Macro DECODER_HIT_CNT_EN SHALL gate the hit-counter feature.
REQ-029 With DECODER_HIT_CNT_EN defined: cntN SHALL increment by 1 on each acceptance of code N, saturating at 8'hFF; hit_cnt port SHALL exist.
REQ-030 Without DECODER_HIT_CNT_EN: no counters or hit_cnt port; all other behaviour identical.

Verification
REQ-031 HOLD_CYC=4; after rst, pulse in_valid with code=2'b11 -> Y=4'b1000 for cycles 1..4 after acceptance, 4'b0000 at cycle 5, in_ready back high at cycle 5.
REQ-032 Sequence codes 11,10,01,00 with in_valid held high -> Y=1000,0100,0010,0001 each for 4 cycles, acceptances spaced exactly 5 cycles.
REQ-033 HOLD_CYC=1; in_valid held high, code=2'b01 -> Y alternates 4'b0010/4'b0000 every cycle, in_ready toggles inversely.
REQ-034 Change code to 2'b00 during HOLD of code 2'b10 -> Y stays 4'b0100 until hold ends; 2'b00 accepted only on the next IDLE cycle.
REQ-035 Assert rst at the second HOLD cycle of code 2'b01 -> next cycle Y=4'b0000, y_valid=0, busy=0, in_ready=1.
REQ-036 With DECODER_HIT_CNT_EN, accept code 2'b10 300 times -> cnt2=8'hFF, cnt0=cnt1=cnt3=0; rst -> all counters 0.

Source files
------------

// File: rtl/decoder_2to4_sync.sv
// decoder_2to4_sync: 2:4 one-hot decoder that holds each word on Y for HOLD_CYC cycles.
// Optional per-code saturating hit counters under DECODER_HIT_CNT_EN.
module decoder_2to4_sync #(
    parameter int HOLD_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] code,
    output logic [3:0] Y,
    output logic       y_valid,
    output logic       busy
`ifdef DECODER_HIT_CNT_EN
    ,
    output logic [31:0] hit_cnt
`endif
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t     r_state;
    logic [7:0] r_cnt;
    logic [3:0] r_y;
    logic       r_busy;
    logic       w_accept;
    assign in_ready = (r_state == IDLE);
    assign w_accept = in_valid & in_ready;
    assign Y        = r_y;
    assign y_valid  = r_busy;
    assign busy     = r_busy;
    // r_cnt counts the remaining hold cycles after the current one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_y     <= 4'b0000;
            r_busy  <= 1'b0;
            r_cnt   <= 8'd0;
        end else if (r_state == IDLE) begin
            if (w_accept) begin
                r_state <= HOLD;
                r_y     <= 4'b0001 << code;
                r_busy  <= 1'b1;
                r_cnt   <= 8'(HOLD_CYC - 1);
            end
        end else if (r_cnt == 8'd0) begin
            r_state <= IDLE;
            r_y     <= 4'b0000;
            r_busy  <= 1'b0;
        end else begin
            r_cnt <= r_cnt - 8'd1;
        end
    end
`ifdef DECODER_HIT_CNT_EN
    logic [7:0] r_hit [4];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_hit[i] <= 8'd0;
        end else if (w_accept && r_hit[code] != 8'hFF) begin
            r_hit[code] <= r_hit[code] + 8'd1;
        end
    end
    assign hit_cnt = {r_hit[3], r_hit[2], r_hit[1], r_hit[0]};
`endif
endmodule

// File: tb/tb_decoder_2to4_sync.sv
// tb_decoder_2to4_sync: directed vectors feed expected-output queues; monitors compare one cycle later.
// Hit-counter checks compile only with DECODER_HIT_CNT_EN.
module tb_decoder_2to4_sync;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       v4 = 1'b0, v1 = 1'b0;
    logic [1:0] c4 = 2'd0, c1 = 2'd0;
    logic       rdy4, rdy1, yv4, yv1, bz4, bz1;
    logic [3:0] y4, y1;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [6:0] q4[$];
    logic [6:0] q1[$];
`ifdef DECODER_HIT_CNT_EN
    logic [31:0] hc4, hc1;
`endif

    always #5 clk = ~clk;

    decoder_2to4_sync #(.HOLD_CYC(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .code(c4),
        .Y(y4), .y_valid(yv4), .busy(bz4)
`ifdef DECODER_HIT_CNT_EN
        , .hit_cnt(hc4)
`endif
    );

    decoder_2to4_sync #(.HOLD_CYC(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .code(c1),
        .Y(y1), .y_valid(yv1), .busy(bz1)
`ifdef DECODER_HIT_CNT_EN
        , .hit_cnt(hc1)
`endif
    );

    // expected tuple {Y, y_valid, busy, in_ready}; idle always means Y==0 and ready
    function automatic logic [6:0] exp_of(input logic [3:0] ey);
        return {ey, |ey, |ey, ~|ey};
    endfunction

    task automatic t4(input logic r, input logic v, input logic [1:0] c, input logic [3:0] ey);
        @(negedge clk);
        rst = r; v4 = v; c4 = c;
        q4.push_back(exp_of(ey));
    endtask

    task automatic t1(input logic r, input logic v, input logic [1:0] c, input logic [3:0] ey);
        @(negedge clk);
        rst = r; v1 = v; c1 = c;
        q1.push_back(exp_of(ey));
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (q4.size() != 0) begin
            logic [6:0] e;
            e = q4.pop_front();
            n_cmp++;
            if ({y4, yv4, bz4, rdy4} !== e) begin
                n_bad++;
                $display("FAIL h4_out t=%0t got {Y,vld,busy,rdy}=%b required %b", $time, {y4, yv4, bz4, rdy4}, e);
            end
        end
        if (q1.size() != 0) begin
            logic [6:0] e;
            e = q1.pop_front();
            n_cmp++;
            if ({y1, yv1, bz1, rdy1} !== e) begin
                n_bad++;
                $display("FAIL h1_out t=%0t got {Y,vld,busy,rdy}=%b required %b", $time, {y1, yv1, bz1, rdy1}, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    logic [3:0] oh [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [1:0] seq [4] = '{2'd3, 2'd2, 2'd1, 2'd0};

    initial begin
        // reset, single pulse of code 3
        t4(1, 0, 0, 4'b0000);
        t4(1, 0, 0, 4'b0000);
        t4(0, 1, 3, 4'b1000);
        t4(0, 0, 0, 4'b1000);
        t4(0, 0, 0, 4'b1000);
        t4(0, 0, 0, 4'b1000);
        t4(0, 0, 0, 4'b0000);
        t4(0, 0, 0, 4'b0000);
        // held in_valid, codes 11,10,01,00 spaced 5 cycles
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) t4(0, 1, seq[i], oh[seq[i]]);
            t4(0, 1, seq[i], 4'b0000);
        end
        t4(0, 0, 0, 4'b0000);
        // code changes during hold are ignored, new code taken on next idle cycle
        t4(0, 1, 2, 4'b0100);
        t4(0, 1, 0, 4'b0100);
        t4(0, 1, 0, 4'b0100);
        t4(0, 1, 0, 4'b0100);
        t4(0, 1, 0, 4'b0000);
        t4(0, 1, 0, 4'b0001);
        t4(0, 0, 3, 4'b0001);
        t4(0, 0, 3, 4'b0001);
        t4(0, 0, 3, 4'b0001);
        t4(0, 0, 3, 4'b0000);
        // reset mid-hold aborts; reset beats acceptance
        t4(0, 1, 1, 4'b0010);
        t4(0, 0, 1, 4'b0010);
        t4(1, 0, 1, 4'b0000);
        t4(1, 1, 3, 4'b0000);
        t4(0, 0, 0, 4'b0000);
        t4(0, 0, 0, 4'b0000);
        // HOLD_CYC=1: pulse / gap alternation with in_valid held
        t1(1, 0, 0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            t1(0, 1, 1, 4'b0010);
            t1(0, 1, 1, 4'b0000);
        end
        t1(0, 0, 1, 4'b0000);
        t1(0, 1, 3, 4'b1000);
        t1(0, 0, 0, 4'b0000);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (q4.size() != 0 || q1.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain got %0d/%0d left required 0/0", q4.size(), q1.size());
        end
`ifdef DECODER_HIT_CNT_EN
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0; v1 = 1; c1 = 2;
        repeat (600) @(negedge clk);
        v1 = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (hc1 !== 32'h00FF_0000) begin
            n_bad++;
            $display("FAIL hit_sat got %h required %h", hc1, 32'h00FF_0000);
        end
        rst = 1;
        @(negedge clk);
        rst = 0;
        n_cmp++;
        if (hc1 !== 32'h0 || hc4 !== 32'h0) begin
            n_bad++;
            $display("FAIL hit_rst got %h/%h required 0/0", hc1, hc4);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
